mem_port_arbiter: RTL and testbench

- Front end that sits directly upstream of the unified RAM/ROM memory system.
- Accepts instruction-fetch and data load/store requests, and serialises them onto the single memory port (address, write data, write enable).
- Captures the memory read data and returns it to the requester with a valid pulse.
- Rejects misaligned accesses with an error response; a rejected access never reaches memory.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state encoding, requester IDs and alignment helpers shared by
// the memory port arbiter and its grant picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // A word access is legal only when the two byte-offset bits are clear.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the
// single memory port seen by the arbiter. The slave modport is the arbiter
// itself; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  if_req_i;
    logic [DATA_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_valid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [DATA_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_valid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  err_o;

    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_valid_o, if_rdata_o,
        output d_gnt_o, d_valid_o, d_rdata_o,
        output err_o,
        output mem_addr_o, mem_wdata_o, mem_we_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_valid_o, if_rdata_o,
        input  d_gnt_o, d_valid_o, d_rdata_o,
        input  err_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o,
        input  busy_o
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational grant selection between the fetch and data
// requesters. Grants are only produced while the arbiter is idle, and never
// more than one at a time.
// Optional macro MEM_ARB_RR_EN: ties alternate using the last-winner input;
// without it, data always beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic last_winner,
`endif
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    // Pick at most one winner; a lone requester always wins.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (idle) begin
`ifdef MEM_ARB_RR_EN
            if (if_req && d_req) begin
                if (last_winner == REQ_IF) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req;
            end
`else
            d_gnt  = d_req;
            if_gnt = if_req & ~d_req;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction fetches and data loads/stores onto
// a single RAM/ROM port, returns read data with a one-cycle valid strobe and
// rejects misaligned accesses with an error response that never touches
// memory.
// Optional macro MEM_ARB_RR_EN: round-robin tie breaking between fetch and
// data; default build uses fixed data-over-fetch priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY);

    arb_state_t            state;
    logic                  lat_id;
    logic                  lat_we;
    logic [1:0]            cnt;

    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  if_valid_q;
    logic                  d_valid_q;
    logic                  err_q;
    logic                  busy_q;

    logic                  idle;
    logic                  if_gnt;
    logic                  d_gnt;
    logic                  any_gnt;
    logic                  gnt_id;
    logic                  gnt_we;
    logic [DATA_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    // Grants are held off while reset is asserted so every output reads 0.
    assign idle    = (state == IDLE) && reset_i;
    assign any_gnt = if_gnt | d_gnt;

`ifdef MEM_ARB_RR_EN
    logic last_winner;

    // Remember who won the most recent contested grant; uncontested grants
    // leave it alone so the next tie goes to the other requester.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last_winner <= REQ_IF;
        end else if (idle && bus.if_req_i && bus.d_req_i) begin
            last_winner <= d_gnt ? REQ_D : REQ_IF;
        end
    end

    mem_arb_pick u_pick (
        .last_winner (last_winner),
        .idle        (idle),
        .if_req      (bus.if_req_i),
        .d_req       (bus.d_req_i),
        .if_gnt      (if_gnt),
        .d_gnt       (d_gnt)
    );
`else
    mem_arb_pick u_pick (
        .idle   (idle),
        .if_req (bus.if_req_i),
        .d_req  (bus.d_req_i),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );
`endif

    // Select the fields of whichever requester is being granted this cycle.
    always_comb begin
        gnt_id    = REQ_IF;
        gnt_we    = 1'b0;
        gnt_addr  = bus.if_addr_i;
        gnt_wdata = '0;
        if (d_gnt) begin
            gnt_id    = REQ_D;
            gnt_we    = bus.d_we_i;
            gnt_addr  = bus.d_addr_i;
            gnt_wdata = bus.d_wdata_i;
        end
    end

    // Main sequencer: latch on grant, drive the memory port during ISSUE,
    // capture read data on the last ISSUE edge and strobe the response.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            lat_id      <= REQ_IF;
            lat_we      <= 1'b0;
            cnt         <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        lat_id <= gnt_id;
                        lat_we <= gnt_we;
                        cnt    <= 2'd0;
                        busy_q <= 1'b1;
                        if (is_aligned(gnt_addr[1:0])) begin
                            state       <= ISSUE;
                            mem_addr_q  <= gnt_addr;
                            mem_wdata_q <= gnt_wdata;
                            mem_we_q    <= gnt_we;
                        end else begin
                            state      <= RESP;
                            err_q      <= 1'b1;
                            if_valid_q <= (gnt_id == REQ_IF);
                            d_valid_q  <= (gnt_id == REQ_D);
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        state      <= RESP;
                        if_valid_q <= (lat_id == REQ_IF);
                        d_valid_q  <= (lat_id == REQ_D);
                    end else if (cnt == LAST_CNT) begin
                        state <= RESP;
                        if (lat_id == REQ_D) begin
                            d_rdata_q <= bus.mem_rdata_i;
                            d_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata_i;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.d_valid_o   = d_valid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.err_o       = err_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed bench for mem_port_arbiter.
// The main instance (READ_LATENCY = 1) is checked every cycle against a
// transaction-level schedule model; two extra instances cover latency 0 and 3.
// Honours MEM_ARB_RR_EN in its reference model.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int SZ  = 4096;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks;
    int n_errors;
    int cyc;
    int free_at;

    logic        if_pend, d_pend, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        last_tie_if;
    logic [31:0] m_addr, m_if_rdata, m_d_rdata;

    logic [1:0]  s_port    [SZ];
    logic        s_err     [SZ];
    logic        s_load    [SZ];
    logic [31:0] s_data    [SZ];
    logic        s_we      [SZ];
    logic [31:0] s_wdata   [SZ];
    logic        s_addr_ok [SZ];
    logic [31:0] s_addr    [SZ];

    logic [31:0] rd_l1, rd3_a, rd3_b, rd3_c;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus_main ();
    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus_l0 ();
    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus_l3 ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(LAT)) dut_main (
        .clk_i(clk), .reset_i(reset_n), .bus(bus_main));
    mem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(0)) dut_l0 (
        .clk_i(clk), .reset_i(reset_n), .bus(bus_l0));
    mem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(3)) dut_l3 (
        .clk_i(clk), .reset_i(reset_n), .bus(bus_l3));

    // Memory contents: a fixed scramble of the address, plus the known word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h2008_0005;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memories with read latency 0, 1 and 3 clocks.
    assign bus_l0.mem_rdata_i = mem_word(bus_l0.mem_addr_o);
    always @(posedge clk) rd_l1 <= mem_word(bus_main.mem_addr_o);
    assign bus_main.mem_rdata_i = rd_l1;
    always @(posedge clk) begin
        rd3_a <= mem_word(bus_l3.mem_addr_o);
        rd3_b <= rd3_a;
        rd3_c <= rd3_b;
    end
    assign bus_l3.mem_rdata_i = rd3_c;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SZ; i++) begin
            s_port[i] = 2'd0; s_err[i] = 1'b0; s_load[i] = 1'b0; s_data[i] = '0;
            s_we[i] = 1'b0; s_wdata[i] = '0; s_addr_ok[i] = 1'b0; s_addr[i] = '0;
        end
        free_at = 0;
        m_addr = '0; m_if_rdata = '0; m_d_rdata = '0;
        last_tie_if = 1'b1;
        if_pend = 1'b0; d_pend = 1'b0;
    endtask

    // Record the future events of an access granted in the current cycle.
    task automatic schedule(input logic is_d, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        int t;
        if (addr[1:0] != 2'b00) begin
            t = cyc + 1;
            s_err[t] = 1'b1;
            free_at = cyc + 2;
        end else if (we) begin
            s_we[cyc+1] = 1'b1; s_wdata[cyc+1] = wdata;
            s_addr_ok[cyc+1] = 1'b1; s_addr[cyc+1] = addr;
            t = cyc + 2;
            free_at = cyc + 3;
        end else begin
            s_addr_ok[cyc+1] = 1'b1; s_addr[cyc+1] = addr;
            t = cyc + LAT + 2;
            s_load[t] = 1'b1; s_data[t] = mem_word(addr);
            free_at = t + 1;
        end
        s_port[t] = is_d ? 2'd2 : 2'd1;
    endtask

    task automatic model_and_check();
        logic e_busy, e_if_gnt, e_d_gnt, d_wins;
        e_busy = (cyc < free_at);
        e_if_gnt = 1'b0;
        e_d_gnt = 1'b0;
        if (!e_busy && (if_pend || d_pend)) begin
`ifdef MEM_ARB_RR_EN
            d_wins = d_pend && (!if_pend || last_tie_if);
            if (if_pend && d_pend) last_tie_if = !d_wins;
`else
            d_wins = d_pend;
`endif
            e_d_gnt = d_wins;
            e_if_gnt = !d_wins;
            if (d_wins) begin
                schedule(1'b1, d_addr, d_we, d_wdata);
                d_pend = 1'b0;
            end else begin
                schedule(1'b0, if_addr, 1'b0, 32'h0);
                if_pend = 1'b0;
            end
        end
        if (s_addr_ok[cyc]) m_addr = s_addr[cyc];
        if (s_load[cyc]) begin
            if (s_port[cyc] == 2'd2) m_d_rdata = s_data[cyc];
            else m_if_rdata = s_data[cyc];
        end
        check_output("if_gnt", 32'(bus_main.if_gnt_o), 32'(e_if_gnt));
        check_output("d_gnt", 32'(bus_main.d_gnt_o), 32'(e_d_gnt));
        check_output("busy", 32'(bus_main.busy_o), 32'(e_busy));
        check_output("if_valid", 32'(bus_main.if_valid_o), 32'(s_port[cyc] == 2'd1));
        check_output("d_valid", 32'(bus_main.d_valid_o), 32'(s_port[cyc] == 2'd2));
        check_output("err", 32'(bus_main.err_o), 32'(s_err[cyc]));
        check_output("mem_we", 32'(bus_main.mem_we_o), 32'(s_we[cyc]));
        if (s_we[cyc]) check_output("mem_wdata", bus_main.mem_wdata_o, s_wdata[cyc]);
        check_output("mem_addr", bus_main.mem_addr_o, m_addr);
        check_output("if_rdata", bus_main.if_rdata_o, m_if_rdata);
        check_output("d_rdata", bus_main.d_rdata_o, m_d_rdata);
        s_port[cyc] = 2'd0; s_err[cyc] = 1'b0; s_load[cyc] = 1'b0;
        s_we[cyc] = 1'b0; s_addr_ok[cyc] = 1'b0;
    endtask

    // Non-pending ports get random fields so post-grant changes are exercised.
    task automatic drive_inputs();
        bus_main.if_req_i  = if_pend;
        bus_main.if_addr_i = if_pend ? if_addr : $urandom;
        bus_main.d_req_i   = d_pend;
        bus_main.d_we_i    = d_pend ? d_we : 1'($urandom);
        bus_main.d_addr_i  = d_pend ? d_addr : $urandom;
        bus_main.d_wdata_i = d_pend ? d_wdata : $urandom;
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        model_and_check();
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic gen_requests();
        if (!if_pend) begin
            if ($urandom_range(0, 3) == 0) begin if_pend = 1'b1; if_addr = rand_addr(); end
        end else if ($urandom_range(0, 24) == 0) begin
            if_pend = 1'b0;
        end
        if (!d_pend) begin
            if ($urandom_range(0, 3) == 0) begin
                d_pend = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom); d_wdata = $urandom;
            end
        end else if ($urandom_range(0, 24) == 0) begin
            d_pend = 1'b0;
        end
    endtask

    // One load on the latency-0 (sel 0) or latency-3 (sel 1) instance.
    task automatic run_latency_load(input int sel, input logic [31:0] addr, input int lat);
        int gnt_at, val_at;
        logic g, v, e;
        logic [31:0] rd;
        gnt_at = -1; val_at = -1; rd = '0; e = 1'b0;
        @(posedge clk);
        #1;
        if (sel == 0) begin bus_l0.d_req_i = 1'b1; bus_l0.d_we_i = 1'b0; bus_l0.d_addr_i = addr; end
        else begin bus_l3.d_req_i = 1'b1; bus_l3.d_we_i = 1'b0; bus_l3.d_addr_i = addr; end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g = (sel == 0) ? bus_l0.d_gnt_o : bus_l3.d_gnt_o;
            v = (sel == 0) ? bus_l0.d_valid_o : bus_l3.d_valid_o;
            if (g && gnt_at < 0) gnt_at = k;
            if (v && val_at < 0) begin
                val_at = k;
                rd = (sel == 0) ? bus_l0.d_rdata_o : bus_l3.d_rdata_o;
                e = (sel == 0) ? bus_l0.err_o : bus_l3.err_o;
            end
            @(posedge clk);
            #1;
            if (gnt_at >= 0) begin
                if (sel == 0) begin bus_l0.d_req_i = 1'b0; bus_l0.d_addr_i = $urandom; end
                else begin bus_l3.d_req_i = 1'b0; bus_l3.d_addr_i = $urandom; end
            end
        end
        check_output("lat_grant", 32'(gnt_at), 32'd0);
        check_output("lat_cycles", 32'(val_at - gnt_at), 32'(lat + 2));
        check_output("lat_rdata", rd, mem_word(addr));
        check_output("lat_err", 32'(e), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        model_reset();
        if_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
        drive_inputs();
        bus_l0.if_req_i = 1'b0; bus_l0.if_addr_i = '0; bus_l0.d_req_i = 1'b0;
        bus_l0.d_we_i = 1'b0; bus_l0.d_addr_i = '0; bus_l0.d_wdata_i = '0;
        bus_l3.if_req_i = 1'b0; bus_l3.if_addr_i = '0; bus_l3.d_req_i = 1'b0;
        bus_l3.d_we_i = 1'b0; bus_l3.d_addr_i = '0; bus_l3.d_wdata_i = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_if_valid", 32'(bus_main.if_valid_o), 32'd0);
        check_output("rst_d_valid", 32'(bus_main.d_valid_o), 32'd0);
        check_output("rst_err", 32'(bus_main.err_o), 32'd0);
        check_output("rst_mem_we", 32'(bus_main.mem_we_o), 32'd0);
        check_output("rst_mem_addr", bus_main.mem_addr_o, 32'd0);
        check_output("rst_mem_wdata", bus_main.mem_wdata_o, 32'd0);
        check_output("rst_if_rdata", bus_main.if_rdata_o, 32'd0);
        check_output("rst_d_rdata", bus_main.d_rdata_o, 32'd0);
        check_output("rst_busy", 32'(bus_main.busy_o), 32'd0);
        reset_n = 1'b1;

        // Aligned fetch with a known memory word.
        if_pend = 1'b1; if_addr = 32'h0040_0004;
        apply_stimulus();
        check_output("fetch_gnt_c0", 32'(bus_main.if_gnt_o), 32'd1);
        apply_stimulus();
        check_output("fetch_addr_c1", bus_main.mem_addr_o, 32'h0040_0004);
        apply_stimulus();
        check_output("fetch_addr_c2", bus_main.mem_addr_o, 32'h0040_0004);
        apply_stimulus();
        check_output("fetch_valid_c3", 32'(bus_main.if_valid_o), 32'd1);
        check_output("fetch_rdata", bus_main.if_rdata_o, 32'h2008_0005);
        repeat (2) apply_stimulus();

        // Store: one write-enable cycle, ack two cycles after grant.
        d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
        apply_stimulus();
        apply_stimulus();
        check_output("store_we_c1", 32'(bus_main.mem_we_o), 32'd1);
        check_output("store_addr_c1", bus_main.mem_addr_o, 32'h1001_0008);
        check_output("store_wdata_c1", bus_main.mem_wdata_o, 32'hDEAD_BEEF);
        apply_stimulus();
        check_output("store_we_c2", 32'(bus_main.mem_we_o), 32'd0);
        check_output("store_valid_c2", 32'(bus_main.d_valid_o), 32'd1);
        repeat (2) apply_stimulus();

        // Two simultaneous pairs exercise the tie-break rule.
        for (int p = 0; p < 2; p++) begin
            if_pend = 1'b1; if_addr = 32'h0000_0100 + 32'(p * 16);
            d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200 + 32'(p * 16);
            repeat (12) apply_stimulus();
        end

        // Misaligned load: error strobe one cycle after grant, memory untouched.
        d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0002;
        apply_stimulus();
        apply_stimulus();
        check_output("misal_err_c1", 32'(bus_main.err_o), 32'd1);
        check_output("misal_valid_c1", 32'(bus_main.d_valid_o), 32'd1);
        repeat (2) apply_stimulus();

        // Reset during the ISSUE cycle of a store.
        d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'h1234_5678;
        apply_stimulus();
        @(posedge clk);
        #1;
        drive_inputs();
        #2;
        check_output("abort_we_before", 32'(bus_main.mem_we_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("abort_we", 32'(bus_main.mem_we_o), 32'd0);
        check_output("abort_busy", 32'(bus_main.busy_o), 32'd0);
        check_output("abort_addr", bus_main.mem_addr_o, 32'd0);
        check_output("abort_d_rdata", bus_main.d_rdata_o, 32'd0);
        check_output("abort_if_rdata", bus_main.if_rdata_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        cyc = cyc + 4;
        repeat (5) apply_stimulus();
        d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
        repeat (6) apply_stimulus();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            gen_requests();
            apply_stimulus();
        end
        if_pend = 1'b0;
        d_pend = 1'b0;
        repeat (8) apply_stimulus();

        // Latency sweep on the extra instances.
        run_latency_load(0, 32'h0000_1230, 0);
        run_latency_load(0, 32'h0040_0004, 0);
        run_latency_load(1, 32'h0000_4560, 3);
        run_latency_load(1, 32'h0040_0004, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
